// File: rtl/decimator_accum.sv
// Multi-channel sample decimator for the IAGC datapath.
// Counts qualified samples on one shared phase counter and emits one result per
// D accepted samples: either the D-th sample (PICK) or the full-precision sum of
// all D samples (ACCUM). The D-th result bypasses the accumulator register so
// the strobe lands on the same edge that accepts the last sample of the frame.
module decimator_accum #(
   parameter int IAGC_STATUS_SIZE = 4,
   parameter int DECIMATOR_SIZE   = 4,
   parameter int DATA_WIDTH       = 14,
   parameter int N_CHANNELS       = 2
) (
   input  logic                                                  i_clock,
   input  logic                                                  i_reset_n,
   input  logic [IAGC_STATUS_SIZE-1:0]                           i_iagc_status,
   input  logic                                                  i_gate,
   input  logic [DECIMATOR_SIZE-1:0]                             i_decimator,
   input  logic                                                  i_mode,
   input  logic                                                  i_valid,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0]                      i_data,
   output logic                                                  o_valid,
   output logic [N_CHANNELS*(DATA_WIDTH+DECIMATOR_SIZE)-1:0]     o_data,
   output logic [DECIMATOR_SIZE-1:0]                             o_phase
);

   // Sum of up to 2**DECIMATOR_SIZE-1 samples cannot overflow this width.
   localparam int ACC_WIDTH = DATA_WIDTH + DECIMATOR_SIZE;

   localparam logic [IAGC_STATUS_SIZE-1:0] ST_RESET = IAGC_STATUS_SIZE'(0);
   localparam logic [IAGC_STATUS_SIZE-1:0] ST_INIT  = IAGC_STATUS_SIZE'(1);
   localparam logic [DECIMATOR_SIZE-1:0]   ONE      = DECIMATOR_SIZE'(1);

   localparam bit MODE_PICK = 1'b0;

   // state
   logic [DECIMATOR_SIZE-1:0]                 phase_q, phase_d;
   logic [DECIMATOR_SIZE-1:0]                 ratio_q, ratio_d;
   logic                                      mode_q,  mode_d;
   logic                                      valid_q, valid_d;
   logic [N_CHANNELS-1:0][ACC_WIDTH-1:0]      acc_q,   acc_d;
   logic [N_CHANNELS-1:0][ACC_WIDTH-1:0]      odata_q, odata_d;

   // frame-level decode
   logic                                      clear_w;
   logic                                      start_w;
   logic [DECIMATOR_SIZE-1:0]                 ratio_w;
   logic                                      mode_w;
   logic                                      last_w;
   logic [N_CHANNELS-1:0][ACC_WIDTH-1:0]      samp_w;
   logic [N_CHANNELS-1:0][ACC_WIDTH-1:0]      sum_w;
   logic [N_CHANNELS-1:0][ACC_WIDTH-1:0]      res_w;

   // IAGC in RESET/INIT or gate low holds the decimator idle.
   assign clear_w = (i_iagc_status == ST_RESET) || (i_iagc_status == ST_INIT) || !i_gate;

   // Ratio and mode are sampled only by the first sample of a frame; later
   // samples of the frame use the latched copies.
   assign start_w = (phase_q == '0);
   assign ratio_w = start_w ? ((i_decimator == '0) ? ONE : i_decimator) : ratio_q;
   assign mode_w  = start_w ? i_mode : mode_q;
   assign last_w  = (phase_q == (ratio_w - ONE));

   // Per-channel sign extension, running sum and selected result.
   always_comb begin
      for (int c = 0; c < N_CHANNELS; c++) begin
         samp_w[c] = ACC_WIDTH'($signed(i_data[c*DATA_WIDTH +: DATA_WIDTH]));
         sum_w[c]  = start_w ? samp_w[c] : (acc_q[c] + samp_w[c]);
         res_w[c]  = (mode_w == MODE_PICK) ? samp_w[c] : sum_w[c];
      end
   end

   // Next-state: clear dominates, otherwise advance on each valid sample.
   always_comb begin
      phase_d = phase_q;
      ratio_d = ratio_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      odata_d = odata_q;
      valid_d = 1'b0;
      if (clear_w) begin
         phase_d = '0;
         acc_d   = '0;
      end else if (i_valid) begin
         ratio_d = ratio_w;
         mode_d  = mode_w;
         acc_d   = sum_w;
         if (last_w) begin
            phase_d = '0;
            valid_d = 1'b1;
            odata_d = res_w;
         end else begin
            phase_d = phase_q + ONE;
         end
      end
   end

   // State registers with async active-low reset.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         phase_q <= '0;
         ratio_q <= ONE;
         mode_q  <= MODE_PICK;
         valid_q <= 1'b0;
         acc_q   <= '0;
         odata_q <= '0;
      end else begin
         phase_q <= phase_d;
         ratio_q <= ratio_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         acc_q   <= acc_d;
         odata_q <= odata_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = odata_q;
   assign o_phase = phase_q;

endmodule

// File: tb/tb_decimator_accum.sv
// Self-checking bench for decimator_accum: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// frame-buffer model (stores the samples of the current frame, then picks the
// last one or sums them when the frame completes).
module tb_decimator_accum;
   localparam int SS = 4;
   localparam int DS = 4;
   localparam int DW = 14;
   localparam int NC = 2;
   localparam int AW = DW + DS;

   logic                 i_clock = 1'b0;
   logic                 i_reset_n = 1'b1;
   logic [SS-1:0]        i_iagc_status = 4'd2;
   logic                 i_gate = 1'b1;
   logic [DS-1:0]        i_decimator = 4'd1;
   logic                 i_mode = 1'b0;
   logic                 i_valid = 1'b0;
   logic [NC*DW-1:0]     i_data = '0;
   logic                 o_valid;
   logic [NC*AW-1:0]     o_data;
   logic [DS-1:0]        o_phase;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 i_clock = ~i_clock;

   decimator_accum #(
      .IAGC_STATUS_SIZE(SS), .DECIMATOR_SIZE(DS), .DATA_WIDTH(DW), .N_CHANNELS(NC)
   ) dut (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_iagc_status(i_iagc_status),
      .i_gate(i_gate), .i_decimator(i_decimator), .i_mode(i_mode),
      .i_valid(i_valid), .i_data(i_data), .o_valid(o_valid), .o_data(o_data),
      .o_phase(o_phase)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int out_ch(input int c);
      logic signed [AW-1:0] v;
      v = o_data[c*AW +: AW];
      return int'(v);
   endfunction

   function automatic int in_ch(input int c);
      logic signed [DW-1:0] v;
      v = i_data[c*DW +: DW];
      return int'(v);
   endfunction

   // ---------------- reference model ----------------
   int fr[NC][16];
   int nsamp = 0;
   int m_d = 1;
   bit m_mode = 1'b0;
   bit exp_valid = 1'b0;
   int exp_data[NC] = '{default: 0};

   initial begin
      forever begin
         @(posedge i_clock or negedge i_reset_n);
         if (!i_reset_n) begin
            nsamp = 0; m_d = 1; m_mode = 1'b0; exp_valid = 1'b0;
            foreach (exp_data[c]) exp_data[c] = 0;
         end else begin
            exp_valid = 1'b0;
            if (i_iagc_status < 2 || !i_gate) begin
               nsamp = 0;
            end else if (i_valid) begin
               if (nsamp == 0) begin
                  m_d = (i_decimator == 0) ? 1 : int'(i_decimator);
                  m_mode = i_mode;
               end
               for (int c = 0; c < NC; c++) fr[c][nsamp] = in_ch(c);
               nsamp++;
               if (nsamp == m_d) begin
                  exp_valid = 1'b1;
                  for (int c = 0; c < NC; c++) begin
                     int s;
                     s = 0;
                     for (int k = 0; k < m_d; k++) s += fr[c][k];
                     exp_data[c] = m_mode ? s : fr[c][m_d-1];
                  end
                  nsamp = 0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge i_clock);
         if (chk_en) begin
            check("model o_valid", o_valid, exp_valid);
            check("model o_phase", o_phase, nsamp);
            for (int c = 0; c < NC; c++) check($sformatf("model o_data ch%0d", c), out_ch(c), exp_data[c]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input bit v, input int d0, input int d1);
      logic [DW-1:0] a, b;
      a = DW'(d0); b = DW'(d1);
      i_valid = v;
      i_data  = {b, a};
      @(posedge i_clock);
      #1;
   endtask

   task automatic cfg(input int dec, input bit mode);
      i_decimator = DS'(dec);
      i_mode = mode;
   endtask

   // One gated-off cycle returns the frame to phase 0.
   task automatic flush();
      i_gate = 1'b0;
      cyc(1'b0, 0, 0);
      i_gate = 1'b1;
   endtask

   initial begin
      int prev;
      #1 i_reset_n = 1'b0;
      #1 chk_en = 1'b1;
      #1;
      check("reset o_valid", o_valid, 0);
      check("reset o_data ch0", out_ch(0), 0);
      check("reset o_phase", o_phase, 0);
      @(posedge i_clock); #1;
      @(posedge i_clock); #1;
      i_reset_n = 1'b1;

      // PICK, D=3, continuous valid, ch0 counts 1..9
      cfg(3, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         cyc(1'b1, k, -k);
         check("pick d3 strobe", o_valid, (k % 3 == 0));
         if (k % 3 == 0) check("pick d3 ch0", out_ch(0), k);
      end

      // ACCUM, D=4, extremes
      cfg(4, 1'b1);
      for (int k = 1; k <= 4; k++) cyc(1'b1, -8192, 8191);
      check("accum d4 strobe", o_valid, 1);
      check("accum d4 ch0", out_ch(0), -32768);
      check("accum d4 ch1", out_ch(1), 32764);

      // ACCUM, D=15, largest ratio
      cfg(15, 1'b1);
      for (int k = 1; k <= 15; k++) cyc(1'b1, 8191, -8192);
      check("accum d15 strobe", o_valid, 1);
      check("accum d15 ch0", out_ch(0), 122865);
      check("accum d15 ch1", out_ch(1), -122880);

      // Async reset mid-frame: ACCUM D=4 after 2 samples
      cfg(4, 1'b1);
      cyc(1'b1, 5, 5);
      cyc(1'b1, 6, 6);
      check("pre-reset phase", o_phase, 2);
      i_reset_n = 1'b0;
      #1;
      check("async reset o_data", out_ch(0), 0);
      check("async reset o_phase", o_phase, 0);
      check("async reset o_valid", o_valid, 0);
      @(posedge i_clock); #1;
      i_reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b1, 10 * k, -k);
         check("post-reset strobe", o_valid, (k == 4));
      end
      check("post-reset sum ch0", out_ch(0), 100);
      check("post-reset sum ch1", out_ch(1), -10);

      // Toggling valid, D=2, PICK: strobe every 4 cycles
      cfg(2, 1'b0);
      for (int i = 0; i < 16; i++) begin
         cyc((i % 2) == 0, i, 0);
         check("toggle strobe", o_valid, (i % 4 == 2));
      end

      // D=0 behaves as D=1 in both modes
      cfg(0, 1'b1);
      cyc(1'b1, 7, -3);
      check("d0 strobe", o_valid, 1);
      check("d0 ch0", out_ch(0), 7);
      check("d0 ch1", out_ch(1), -3);
      cfg(0, 1'b0);
      cyc(1'b1, -100, 42);
      check("d0 pick b2b strobe", o_valid, 1);
      check("d0 pick ch0", out_ch(0), -100);

      // D change 4->2 after first sample: this frame 4, then 2
      flush();
      cfg(4, 1'b0);
      cyc(1'b1, 1, 0);
      cfg(2, 1'b0);
      for (int k = 2; k <= 8; k++) begin
         cyc(1'b1, k, 0);
         check("dchange strobe", o_valid, (k == 4 || k == 6 || k == 8));
         if (k == 4 || k == 6 || k == 8) check("dchange ch0", out_ch(0), k);
      end

      // Gate low at phase 2 on the would-be D-th sample (D=3): clear wins
      cfg(3, 1'b0);
      cyc(1'b1, 1, 1); cyc(1'b1, 2, 2); cyc(1'b1, 33, 3);
      prev = out_ch(0);
      check("gate setup ch0", prev, 33);
      cyc(1'b1, 4, 4); cyc(1'b1, 5, 5);
      check("gate phase2", o_phase, 2);
      i_gate = 1'b0;
      cyc(1'b1, 6, 6);
      i_gate = 1'b1;
      check("gate no strobe", o_valid, 0);
      check("gate phase0", o_phase, 0);
      check("gate hold ch0", out_ch(0), prev);

      // Status=INIT behaves the same
      cyc(1'b1, 7, 7); cyc(1'b1, 8, 8);
      i_iagc_status = 4'd1;
      cyc(1'b1, 9, 9);
      i_iagc_status = 4'd2;
      check("init no strobe", o_valid, 0);
      check("init phase0", o_phase, 0);
      check("init hold ch0", out_ch(0), prev);

      // Randomized traffic checked by the model
      for (int i = 0; i < 4000; i++) begin
         int r, d0, d1;
         r = $urandom_range(0, 19);
         i_iagc_status = (r == 0) ? 4'd0 : (r == 1) ? 4'd1 : SS'($urandom_range(2, 15));
         i_gate = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 7) == 0) i_decimator = DS'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) i_mode = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 3) == 0) begin
            d0 = ($urandom_range(0, 1) != 0) ? 8191 : -8192;
            d1 = ($urandom_range(0, 1) != 0) ? 8191 : -8192;
         end else begin
            d0 = int'($urandom_range(0, 16383)) - 8192;
            d1 = int'($urandom_range(0, 16383)) - 8192;
         end
         cyc($urandom_range(0, 9) < 7, d0, d1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
